// File: rtl/booth_radix4_multiplier_if.sv
// Operand/product handshake bundle for booth_radix4_multiplier.
// A transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
interface booth_radix4_multiplier_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] c;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, one digit per enabled cycle, N/2+1 digits per product.
// Optional macro BOOTH_ZERO_BYPASS_EN: zero operands finish after a single cycle with c=0.
module booth_radix4_multiplier #(
    parameter int N = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    booth_radix4_multiplier_if.slave   bus,
    output logic [1:0]                 dbg_state
);
    localparam int W      = N + 2;
    localparam int AW     = 2 * W;
    localparam int DIGITS = N / 2 + 1;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rdy_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   acc_q;
    logic [W-1:0]    ax_q;
    logic            prev_q;

    logic            accept;
    logic            zero_op;
    logic [W-1:0]    ax_in, bx_in;
    logic [W-1:0]    hi, lo;
    logic [W:0]      hi3, a3, pp, sum;
    logic [AW-1:0]   acc_step;

    assign dbg_state = state_q;

    // Operand extension and one Booth step: add digit*a to the upper half, then shift right by 2.
    always_comb begin
        ax_in    = bus.signed_mode ? {{2{bus.a[N-1]}}, bus.a} : {2'b00, bus.a};
        bx_in    = bus.signed_mode ? {{2{bus.b[N-1]}}, bus.b} : {2'b00, bus.b};
`ifdef BOOTH_ZERO_BYPASS_EN
        zero_op  = (bus.a == '0) || (bus.b == '0);
`else
        zero_op  = 1'b0;
`endif
        hi       = acc_q[AW-1:W];
        lo       = acc_q[W-1:0];
        hi3      = {hi[W-1], hi};
        a3       = {ax_q[W-1], ax_q};
        pp       = '0;
        case ({lo[1:0], prev_q})
            3'b001, 3'b010: pp = a3;
            3'b011:         pp = a3 << 1;
            3'b100:         pp = -(a3 << 1);
            3'b101, 3'b110: pp = -a3;
            default:        pp = '0;
        endcase
        // Sum is one bit wider than the upper half so 2a plus the running total cannot overflow.
        sum      = hi3 + pp;
        acc_step = {sum[W], sum, lo[W-1:2]};
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = en && rdy_q;
                accept       = bus.in_valid && en && rdy_q;
                if (accept) state_d = CALC;
            end
            CALC: begin
                if (en && (cnt_q == LAST)) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (en && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bus.c = bus.out_valid ? acc_q[2*N-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            ax_q   <= '0;
            prev_q <= 1'b0;
        end else if (en) begin
            rdy_q <= 1'b1;
            if (accept) begin
                prev_q <= 1'b0;
                if (zero_op) begin
                    // A single all-zero step on the last digit slot lands in DONE one cycle later.
                    ax_q  <= '0;
                    acc_q <= '0;
                    cnt_q <= LAST;
                end else begin
                    ax_q  <= ax_in;
                    acc_q <= {{W{1'b0}}, bx_in};
                    cnt_q <= '0;
                end
            end else if (state_q == CALC) begin
                acc_q  <= acc_step;
                prev_q <= lo[1];
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier (N=32) with hand-computed products and latencies.
module tb_booth_radix4_multiplier;
  localparam int N = 32;
`ifdef BOOTH_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 17;
`endif

  logic clk;
  logic rst;
  logic en;
  logic [1:0] dbg_state;
  int checks;
  int failures;

  booth_radix4_multiplier_if #(.N(N)) bus ();

  booth_radix4_multiplier #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation; pause_at>0 drops en for 3 edges after that edge; hold keeps out_ready low.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tm, input logic [63:0] exp_c, input int exp_lat,
                        input int pause_at, input int hold);
    int lat;
    bit seen;
    logic [63:0] c_seen;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.a           = ta;
    bus.b           = tb_v;
    bus.signed_mode = tm;
    bus.out_ready   = (hold == 0);
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.a           = $urandom;
    bus.b           = $urandom;
    bus.signed_mode = 1'($urandom_range(0, 1));
    check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) seen = 1'b1;
      if (pause_at > 0 && lat == pause_at) en = 1'b0;
      if (pause_at > 0 && lat == pause_at + 3) en = 1'b1;
      if (!seen && bus.in_ready) check({tag, "_in_ready_calc"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_c"}, bus.c, exp_c);
    c_seen = bus.c;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_c"}, bus.c, c_seen);
      check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drop_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_drop_c"}, bus.c, 64'd0);
    check({tag, "_back_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int pulses;
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    en              = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b1;

    // reset state
    #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_c", bus.c, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_in_ready", 64'(bus.in_ready), 64'd1);

    // en=0 in IDLE hides in_ready
    en = 1'b0;
    #1;
    check("en0_in_ready", 64'(bus.in_ready), 64'd0);
    en = 1'b1;

    // basic, mode and corner products
    run_op("basic",     32'd5,          32'd10,         1'b1, 64'd50,                 17, 0, 0);
    run_op("mode_s",    32'd12,         32'hFFFF_FFFD,  1'b1, 64'hFFFF_FFFF_FFFF_FFDC, 17, 0, 0);
    run_op("mode_u",    32'd12,         32'hFFFF_FFFD,  1'b0, 64'h0000_000B_FFFF_FFDC, 17, 0, 0);
    run_op("minneg",    32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, 17, 0, 0);
    run_op("neg12sq",   32'hFFFF_FFF4,  32'hFFFF_FFF4,  1'b1, 64'd144,                17, 0, 0);
    run_op("umax",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, 17, 0, 0);
    run_op("neg1xmax",  32'hFFFF_FFFF,  32'h7FFF_FFFF,  1'b1, 64'hFFFF_FFFF_8000_0001, 17, 0, 0);

    // backpressure and enable stall
    run_op("backpress", 32'd7,          32'd6,          1'b1, 64'd42,                 17, 0, 5);
    run_op("en_stall",  32'h0000_1234,  32'h0000_0100,  1'b1, 64'h0000_0000_0012_3400, 20, 5, 0);

    // en=0 in DONE ignores out_ready
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.a           = 32'd3;
    bus.b           = 32'd3;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("done_en0_valid_pre", 64'(bus.out_valid), 64'd1);
    en            = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("done_en0_hold", 64'(bus.out_valid), 64'd1);
    check("done_en0_c", bus.c, 64'd9);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("done_en1_exit", 64'(bus.out_valid), 64'd0);

    // reset during CALC discards the operation
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.a           = 32'd3;
    bus.b           = 32'd4;
    bus.signed_mode = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_c", bus.c, 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);

    // zero operand, with or without bypass
    run_op("zero_b",    32'd10,         32'd0,          1'b1, 64'd0,                  ZLAT, 0, 0);
    run_op("zero_a",    32'd0,          32'hFFFF_FFFF,  1'b0, 64'd0,                  ZLAT, 0, 0);
    run_op("after_zero", 32'd9,         32'hFFFF_FFF9,  1'b1, 64'hFFFF_FFFF_FFFF_FFC1, 17, 0, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: global enable; 0 freezes all state.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and mode presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, N bits: multiplicand.
REQ-008 The block SHALL have port b, input, N bits: multiplier.
REQ-009 The block SHALL have port signed_mode, input, 1 bit: 1 treats a and b as two's complement; 0 treats them as unsigned.
REQ-010 The block SHALL have port out_valid, output, 1 bit: c holds a completed product.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts c.
REQ-012 The block SHALL have port c, output, 2N bits: product, signed or unsigned per the captured signed_mode.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with en=1.
REQ-015 An accept SHALL occur on an edge with in_valid=1, in_ready=1 and en=1; the block SHALL then capture a, b and signed_mode and move IDLE->CALC.
REQ-016 Operands SHALL be extended to N+2 bits: sign-extended when signed_mode=1, zero-extended when 0.
REQ-017 CALC SHALL retire one radix-4 Booth digit per enabled cycle, from the set {-2a, -a, 0, +a, +2a}.
REQ-018 CALC SHALL use a 2N+4-bit accumulator with an arithmetic shift right by 2 per digit, for exactly N/2+1 digits.
REQ-019 The block SHALL assert out_valid exactly N/2+1 enabled cycles after the accept edge (17 cycles for N=32), with transition CALC->DONE.
REQ-020 c SHALL equal the low 2N bits of the exact product; it SHALL be stable while out_valid=1 and 0 otherwise.
REQ-021 In DONE, an edge with out_ready=1 and en=1 SHALL move the block to IDLE and drop out_valid; there is no same-edge re-accept, so at least one IDLE cycle occurs per operation.
REQ-022 While out_ready=0, the block SHALL hold DONE indefinitely with c unchanged.
REQ-023 in_valid and operand changes during CALC or DONE SHALL be ignored; the in-flight operation is unaffected.
REQ-024 en=0 SHALL hold state, counter and accumulator; in_ready SHALL read 0; out_valid SHALL keep its value; out handshakes on edges with en=0 SHALL be ignored.
REQ-025 Products of the most-negative signed operand SHALL be exact: (-2^(N-1))*(-2^(N-1)) = 2^(2N-2).

Reset
REQ-026 rst=0 SHALL immediately force IDLE, clear the digit counter and accumulator, and drive out_valid=0, c=0 and in_ready=0.
REQ-027 After rst rises, in_ready SHALL be 1 from the first edge onward while en=1.
REQ-028 Reset asserted mid-CALC or in DONE SHALL discard the operation with no out_valid pulse.

Configuration
REQ-029 Macro BOOTH_ZERO_BYPASS_EN SHALL control a zero-operand bypass.
REQ-030 With BOOTH_ZERO_BYPASS_EN defined, an accept with a=0 or b=0 SHALL skip CALC, go directly to DONE and assert out_valid one cycle after accept with c=0.
REQ-031 Without BOOTH_ZERO_BYPASS_EN, zero operands SHALL take the full N/2+1-cycle latency; the product is identical either way.

Verification (N=32)
REQ-032 Basic: a=5, b=10, signed_mode=1 -> out_valid on cycle 17 after accept, c=50; in_ready=0 from accept until DONE exits.
REQ-033 Mode: a=12, b=0xFFFFFFFD -> c=0xFFFFFFFFFFFFFFDC when signed_mode=1; c=0x0000000BFFFFFFDC when signed_mode=0.
REQ-034 Corners: a=b=0x80000000, signed_mode=1 -> c=0x4000000000000000; a=b=0xFFFFFFF4 (-12*-12), signed_mode=1 -> c=144.
REQ-035 Backpressure/enable: hold out_ready=0 for 5 cycles, then 1 -> c stable throughout, one transfer; en=0 for 3 cycles mid-CALC -> latency grows by exactly 3 cycles with the same c.
REQ-036 Reset/bypass: rst=0 at CALC cycle 8 -> no out_valid, next op a=10, b=0 correct; c=0 with out_valid on cycle 1 if BOOTH_ZERO_BYPASS_EN, cycle 17 otherwise.
